// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if -- pipeline redirect bundle between the exception controller
// and the pipeline / CP0 side.
//   master : pipeline/CP0 side (drives requests, receives redirect controls)
//   slave  : exc_ctrl side
// Signals:
//   cp0_req   CP0 Req, exception/interrupt taken this cycle
//   eret_m    ERET present in M stage
//   epc       CP0 EPCOut
//   stall_in  hazard-unit stall
//   flush     clear all pipeline stage registers
//   pc_sel    0 = normal, 1 = handler, 2 = EPC
//   pc_target redirect address (0 when pc_sel == 0)
//   exl_clr   CP0 EXLClr pulse
//   stall_out stall to pipeline
interface exc_ctrl_if;
    logic        cp0_req;
    logic        eret_m;
    logic [31:0] epc;
    logic        stall_in;
    logic        flush;
    logic [1:0]  pc_sel;
    logic [31:0] pc_target;
    logic        exl_clr;
    logic        stall_out;

    modport master (
        output cp0_req, eret_m, epc, stall_in,
        input  flush, pc_sel, pc_target, exl_clr, stall_out
    );

    modport slave (
        input  cp0_req, eret_m, epc, stall_in,
        output flush, pc_sel, pc_target, exl_clr, stall_out
    );
endinterface

// File: rtl/exc_ctrl.sv
// exc_ctrl -- exception / ERET redirect controller.
// Redirects the PC to the exception handler or to EPC, flushes the pipeline
// for the redirect cycle plus one follow-up cycle, registers the interrupt
// vector for CP0 (masked during the ERET follow-up cycle) and optionally
// counts taken exceptions.
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high reset
//   irq_src  raw peripheral interrupt lines (level)
//   HWInt    registered interrupt vector to CP0
//   exc_cnt  saturating count of taken exceptions/interrupts
//   pif      redirect bundle (exc_ctrl_if.slave)
// Build option:
//   EXC_CTRL_CNT_EN  defined: exc_cnt counter is built; undefined: exc_cnt = 0.
//
// state  | meaning
// IDLE   | normal flow, accept cp0_req (priority) or eret_m
// ENTER  | follow-up flush cycle after handler redirect
// RETURN | follow-up flush cycle after ERET, HWInt masked
module exc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  irq_src,
    output logic [5:0]  HWInt,
    output logic [15:0] exc_cnt,
    exc_ctrl_if.slave   pif
);

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
    localparam logic [1:0]  SEL_NORMAL   = 2'd0;
    localparam logic [1:0]  SEL_HANDLER  = 2'd1;
    localparam logic [1:0]  SEL_EPC      = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ENTER  = 2'b01,
        RETURN = 2'b10
    } state_t;

    state_t state;
    state_t state_nxt;

    // Redirect controls are combinational so a redirect lands in the same
    // cycle the request is seen; reset silences them regardless of state.
    always_comb begin
        state_nxt     = IDLE;
        pif.flush     = 1'b0;
        pif.pc_sel    = SEL_NORMAL;
        pif.pc_target = 32'h0;
        pif.exl_clr   = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (pif.cp0_req) begin
                        pif.flush     = 1'b1;
                        pif.pc_sel    = SEL_HANDLER;
                        pif.pc_target = HANDLER_ADDR;
                        state_nxt     = ENTER;
                    end else if (pif.eret_m) begin
                        pif.flush     = 1'b1;
                        pif.pc_sel    = SEL_EPC;
                        pif.pc_target = pif.epc;
                        pif.exl_clr   = 1'b1;
                        state_nxt     = RETURN;
                    end
                end
                ENTER, RETURN: begin
                    pif.flush = 1'b1;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
        pif.stall_out = !reset && pif.stall_in && !pif.flush;
    end

    // HWInt is loaded with zero on the edge entering RETURN so it reads 0
    // for exactly the RETURN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            HWInt <= 6'b0;
        end else begin
            state <= state_nxt;
            HWInt <= (state_nxt == RETURN) ? 6'b0 : irq_src;
        end
    end

`ifdef EXC_CTRL_CNT_EN
    logic [15:0] cnt_q;
    logic        take_exc;

    assign take_exc = (state == IDLE) && pif.cp0_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 16'h0;
        end else if (take_exc && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign exc_cnt = cnt_q;
`else
    assign exc_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl -- randomized self-checking bench for exc_ctrl.
// Reference model: a "follow-up flush pending" flag, an "interrupts masked
// next cycle" rule and a plain integer count of taken exceptions.
module tb_exc_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  irq_src;
    logic [5:0]  HWInt;
    logic [15:0] exc_cnt;

    exc_ctrl_if bus ();

    exc_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .irq_src (irq_src),
        .HWInt   (HWInt),
        .exc_cnt (exc_cnt),
        .pif     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    bit       m_pending;   // current cycle is the follow-up flush cycle
    bit [5:0] m_hw;        // value HWInt must show this cycle
    int       m_cnt;       // taken exceptions, saturating

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit [5:0] irq, input bit req,
                        input bit er, input bit [31:0] e, input bit st);
        bit          e_flush;
        bit [1:0]    e_sel;
        bit [31:0]   e_tgt;
        bit          e_exl;
        bit          e_stall;
        bit          taken;
        bit          returned;
        reset        = rst;
        irq_src      = irq;
        bus.cp0_req  = req;
        bus.eret_m   = er;
        bus.epc      = e;
        bus.stall_in = st;

        e_flush = 0; e_sel = 0; e_tgt = 0; e_exl = 0;
        taken = 0; returned = 0;
        if (!rst) begin
            if (m_pending) begin
                e_flush = 1;
            end else if (req) begin
                e_flush = 1; e_sel = 1; e_tgt = 32'h0000_4180; taken = 1;
            end else if (er) begin
                e_flush = 1; e_sel = 2; e_tgt = e; e_exl = 1; returned = 1;
            end
        end
        e_stall = !rst && st && !e_flush;

        @(negedge clk);
        chk("flush",     bus.flush,     e_flush);
        chk("pc_sel",    bus.pc_sel,    e_sel);
        chk("pc_target", bus.pc_target, e_tgt);
        chk("exl_clr",   bus.exl_clr,   e_exl);
        chk("stall_out", bus.stall_out, e_stall);
        chk("HWInt",     HWInt,         m_hw);
`ifdef EXC_CTRL_CNT_EN
        chk("exc_cnt",   exc_cnt,       m_cnt);
`else
        chk("exc_cnt",   exc_cnt,       0);
`endif

        @(posedge clk);
        #1;
        if (rst) begin
            m_pending = 0;
            m_hw      = 0;
            m_cnt     = 0;
        end else begin
            m_pending = taken || returned;
            m_hw      = returned ? 6'b0 : irq;
            if (taken && m_cnt < 65535) m_cnt = m_cnt + 1;
        end
    endtask

    initial begin
        reset = 1; irq_src = 0;
        bus.cp0_req = 0; bus.eret_m = 0; bus.epc = 0; bus.stall_in = 0;
        @(posedge clk);
        #1;
        m_pending = 0; m_hw = 0; m_cnt = 0;

        // reset with an interrupt pending, then release
        step(1, 6'b000100, 0, 0, 0, 0);
        step(1, 6'b000100, 1, 1, 32'h1234, 1);
        step(0, 6'b000100, 0, 0, 0, 0);
        step(0, 6'b000100, 0, 0, 0, 0);
        chk("hwint_after_release", HWInt, 6'b000100);

        // single exception request
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 32'h55, 0);   // ignored in follow-up cycle
        step(0, 0, 0, 0, 0, 0);

        // ERET with interrupt arriving in the follow-up cycle
        step(0, 0, 0, 1, 32'h0000_3010, 0);
        step(0, 6'b000001, 0, 0, 0, 0);
        step(0, 6'b000001, 0, 0, 0, 0);

        // simultaneous request and ERET under stall
        step(0, 0, 1, 1, 32'hABCD, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // reset during the follow-up cycle aborts the sequence
        step(0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        // reset during the ERET follow-up cycle
        step(0, 6'b111111, 0, 1, 32'h40, 0);
        step(1, 6'b111111, 0, 0, 0, 0);
        step(0, 6'b111111, 0, 0, 0, 0);

`ifdef EXC_CTRL_CNT_EN
        // saturation: preload near the top, then keep requesting
        @(negedge clk);
        force dut.cnt_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.cnt_q;
        m_cnt = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0);
        end
        chk("cnt_saturated", exc_cnt, 16'hFFFF);
        step(1, 0, 0, 0, 0, 0);
`endif

        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(99) < 3),
                 6'($urandom),
                 ($urandom_range(99) < 30),
                 ($urandom_range(99) < 30),
                 $urandom,
                 ($urandom_range(99) < 50));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
